ram_stream_reader: RTL and testbench

- Read-side master for the simple dual-port RAM read port.
- Given a base address and a word count, it issues `re`/`raddr`, absorbs the RAM's 1- or 2-cycle read latency and presents the words as a valid/ready stream.
- Uses credit-based issue into a 4-entry skid FIFO. No word is lost under backpressure, even though the RAM output stage is only valid for one cycle.
- Sits between a RAM instance and any streaming consumer, for example a DMA or a display fetch.

---
 rtl/ram_stream_reader.sv | 216 +++++++++++++++++++++
 tb/tb_ram_stream_reader.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_stream_reader.sv
// Streaming read master for a simple dual-port RAM. It issues reads under credit control and
// parks the returns in a 4-entry skid FIFO. Optional abort input: RAM_STREAM_READER_ABORT_EN.
module ram_stream_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter string       OUTPUT_REG = "TRUE"
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  re,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
`ifdef RAM_STREAM_READER_ABORT_EN
  input  logic                  abort,
`endif
  output logic                  m_last
);

  localparam int unsigned Lat = (OUTPUT_REG == "TRUE") ? 2 : 1;

  typedef enum logic [2:0] {StIdle, StIssue, StDrain, StFin, StAbort} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d, raddr_q, raddr_d;
  logic                  re_q, re_d, re_last_q, re_last_d;
  logic [Lat-1:0]        pipe_vld_q, pipe_vld_d, pipe_last_q, pipe_last_d;
  logic [DATA_WIDTH-1:0] mem_data_q [4];
  logic [3:0]            mem_last_q;
  logic [1:0]            rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [2:0]            count_q, count_d;
  logic                  m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  busy_q, done_q;
  logic [1:0]            wait_q, wait_d;

  logic                  accept, abort_req, push, pop;
  logic [2:0]            inflight_d;
  logic [3:0]            credit_d;
  logic [ADDR_WIDTH:0]   avail;
  logic [ADDR_WIDTH-1:0] ptr_cur;

`ifdef RAM_STREAM_READER_ABORT_EN
  assign abort_req = abort && ((state_q == StIssue) || (state_q == StDrain));
`else
  assign abort_req = 1'b0;
`endif

  // Control FSM
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (length == '0) ? StFin : StIssue;
        end
      end
      StIssue: begin
        // rem_q reaches zero in the same cycle the final re is on the port
        if (rem_q == '0) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (m_valid_q && m_ready && m_last_q) begin
          state_d = StFin;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      StAbort: begin
        if (wait_q == '0) begin
          state_d = StFin;
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    if (abort_req) begin
      state_d = StAbort;
      wait_d  = 2'(Lat - 1);
    end
  end

  // Datapath: in-flight pipe, FIFO bookkeeping, issue decision and stream head
  always_comb begin
    accept  = (state_q == StIdle) && start;
    pop     = m_valid_q && m_ready;
    push    = pipe_vld_q[Lat-1] && !abort_req;
    avail   = accept ? length : rem_q;
    ptr_cur = accept ? base_addr : ptr_q;

    pipe_vld_d[0]  = re_q;
    pipe_last_d[0] = re_last_q;
    for (int unsigned i = 1; i < Lat; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_last_d[i] = pipe_last_q[i-1];
    end

    rd_ptr_d = rd_ptr_q + 2'(pop);
    wr_ptr_d = wr_ptr_q + 2'(push);
    count_d  = count_q + 3'(push) - 3'(pop);
    if (abort_req) begin
      pipe_vld_d  = '0;
      pipe_last_d = '0;
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      count_d     = '0;
    end

    // Credit is judged on next-cycle occupancy because re itself is registered
    inflight_d = '0;
    for (int unsigned i = 0; i < Lat; i++) begin
      inflight_d = inflight_d + 3'(pipe_vld_d[i]);
    end
    credit_d = {1'b0, count_d} + {1'b0, inflight_d};

    re_d      = (accept || (state_q == StIssue)) && (avail != '0) && (credit_d < 4'd4) &&
                !abort_req;
    re_last_d = re_d && (avail == (ADDR_WIDTH+1)'(1));
    rem_d     = avail - (ADDR_WIDTH+1)'(re_d);
    if (abort_req) begin
      rem_d = '0;
    end

    ptr_d   = ptr_cur;
    raddr_d = raddr_q;
    if (re_d) begin
      raddr_d = ptr_cur;
      ptr_d   = ptr_cur + ADDR_WIDTH'(1);
    end

    m_valid_d = (count_d != '0);
    m_data_d  = m_data_q;
    m_last_d  = 1'b0;
    if (count_d != '0) begin
      // FIFO empty once this cycle's pop is done: the word being pushed becomes the head
      if ((count_q == '0) || ((count_q == 3'd1) && pop)) begin
        m_data_d = rdata;
        m_last_d = pipe_last_q[Lat-1];
      end else begin
        m_data_d = mem_data_q[rd_ptr_d];
        m_last_d = mem_last_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= rdata;
      mem_last_q[wr_ptr_q] <= pipe_last_q[Lat-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rem_q       <= '0;
      ptr_q       <= '0;
      raddr_q     <= '0;
      re_q        <= 1'b0;
      re_last_q   <= 1'b0;
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_data_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      ptr_q       <= ptr_d;
      raddr_q     <= raddr_d;
      re_q        <= re_d;
      re_last_q   <= re_last_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_last_q <= pipe_last_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      m_data_q    <= m_data_d;
      busy_q      <= (state_d != StIdle);
      done_q      <= (state_d == StFin);
      wait_q      <= wait_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign re      = re_q;
  assign raddr   = raddr_q;
  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader: two instances (read latency 2 and 1), each behind a
// behavioural RAM whose word at address a is a[7:0].
module tb_ram_stream_reader;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          start_a, start_b, m_ready_a, m_ready_b;
  logic [AW-1:0] base_a, base_b, raddr_a, raddr_b;
  logic [AW:0]   len_a, len_b;
  logic          busy_a, busy_b, done_a, done_b, re_a, re_b;
  logic          m_valid_a, m_valid_b, m_last_a, m_last_b;
  logic [DW-1:0] rdata_a, rdata_b, m_data_a, m_data_b, stage_a;

  ram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUTPUT_REG("TRUE")) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .base_addr(base_a), .length(len_a),
    .busy(busy_a), .done(done_a), .re(re_a), .raddr(raddr_a), .rdata(rdata_a),
    .m_data(m_data_a), .m_valid(m_valid_a), .m_ready(m_ready_a), .m_last(m_last_a)
  );

  ram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUTPUT_REG("FALSE")) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .base_addr(base_b), .length(len_b),
    .busy(busy_b), .done(done_b), .re(re_b), .raddr(raddr_b), .rdata(rdata_b),
    .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(m_ready_b), .m_last(m_last_b)
  );

  // RAM with output register (2 cycles) and without (1 cycle)
  always_ff @(posedge clk) begin
    if (re_a) stage_a <= raddr_a[7:0];
    rdata_a <= stage_a;
  end
  always_ff @(posedge clk) begin
    if (re_b) rdata_b <= raddr_b[7:0];
  end

  bit            sel;
  logic          s_re, s_valid, s_ready, s_last, s_busy, s_done;
  logic [AW-1:0] s_raddr;
  logic [DW-1:0] s_data;

  always_comb begin
    s_re    = sel ? re_b      : re_a;
    s_valid = sel ? m_valid_b : m_valid_a;
    s_ready = sel ? m_ready_b : m_ready_a;
    s_last  = sel ? m_last_b  : m_last_a;
    s_busy  = sel ? busy_b    : busy_a;
    s_done  = sel ? done_b    : done_a;
    s_raddr = sel ? raddr_b   : raddr_a;
    s_data  = sel ? m_data_b  : m_data_a;
  end

  int total = 0;
  int bad   = 0;
  int re_cnt, hs_cnt, done_cnt, max_out, stall_err, last_cnt, last_at;
  bit stalled;
  logic [DW-1:0] stall_data;
  logic          stall_last;
  logic [AW-1:0] addr_log [$];
  logic [DW-1:0] data_log [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    re_cnt = 0; hs_cnt = 0; done_cnt = 0; max_out = 0; stall_err = 0;
    last_cnt = 0; last_at = 0; stalled = 1'b0;
    addr_log.delete();
    data_log.delete();
  endtask

  // Account for the current cycle, then advance to 1 time unit after the next edge.
  task automatic tick();
    #1;
    if (rst_n) begin
      if (stalled && (!s_valid || s_data !== stall_data || s_last !== stall_last)) stall_err++;
      if (s_re) begin
        re_cnt++;
        addr_log.push_back(s_raddr);
      end
      if (re_cnt - hs_cnt > max_out) max_out = re_cnt - hs_cnt;
      if (s_done) done_cnt++;
      if (s_valid && s_ready) begin
        hs_cnt++;
        data_log.push_back(s_data);
        if (s_last) begin
          last_cnt++;
          last_at = hs_cnt;
        end
      end
      stalled    = s_valid && !s_ready;
      stall_data = s_data;
      stall_last = s_last;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [AW-1:0] base, input logic [AW:0] len);
    if (sel) begin
      start_b = 1'b1; base_b = base; len_b = len;
    end else begin
      start_a = 1'b1; base_a = base; len_a = len;
    end
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic run_until_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!s_done && n < budget) begin
      tick();
      n++;
    end
    check(tag, s_done, 1'b1);
  endtask

  initial begin
    int            k;
    int            errs;
    logic [AW-1:0] wrap_addr [4];
    logic [DW-1:0] wrap_data [4];
    wrap_addr = '{9'h1FE, 9'h1FF, 9'h000, 9'h001};
    wrap_data = '{8'hFE, 8'hFF, 8'h00, 8'h01};

    sel = 1'b0;
    start_a = 1'b0; start_b = 1'b0; m_ready_a = 1'b0; m_ready_b = 1'b0;
    base_a = '0; base_b = '0; len_a = '0; len_b = '0;
    clear_log();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_re", re_a, 1'b0);
    check("rst_valid", m_valid_a, 1'b0);
    check("rst_last", m_last_a, 1'b0);
    check("rst_raddr", raddr_a, 9'h000);
    check("rst_data", m_data_a, 8'h00);
    rst_n = 1'b1;
    tick();

    // Basic 8-word read, m_ready held high; a second start while busy must be ignored
    clear_log();
    m_ready_a = 1'b1;
    go(9'h010, 10'd8);
    check("t1_busy", busy_a, 1'b1);
    check("t1_re_first", re_a, 1'b1);
    check("t1_raddr_first", raddr_a, 9'h010);
    check("t1_valid_s1", m_valid_a, 1'b0);
    start_a = 1'b1; base_a = 9'h080; len_a = 10'd3;
    tick();
    start_a = 1'b0;
    check("t1_valid_s2", m_valid_a, 1'b0);
    tick();
    check("t1_valid_s3", m_valid_a, 1'b0);
    tick();
    for (int i = 0; i < 8; i++) begin
      check("t1_valid", m_valid_a, 1'b1);
      check("t1_data", m_data_a, 8'h10 + 8'(i));
      check("t1_last", m_last_a, (i == 7));
      tick();
    end
    check("t1_done", done_a, 1'b1);
    check("t1_busy_fin", busy_a, 1'b1);
    check("t1_valid_fin", m_valid_a, 1'b0);
    tick();
    check("t1_done_off", done_a, 1'b0);
    check("t1_busy_off", busy_a, 1'b0);
    check("t1_re_cnt", re_cnt, 8);
    check("t1_hs_cnt", hs_cnt, 8);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_last_raddr", addr_log[7], 9'h017);

    // Address wrap at the top of the RAM
    clear_log();
    go(9'h1FE, 10'd4);
    run_until_done("t2_done", 40);
    tick();
    check("t2_re_cnt", addr_log.size(), 4);
    check("t2_hs_cnt", data_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < addr_log.size()) check("t2_raddr", addr_log[i], wrap_addr[i]);
      if (i < data_log.size()) check("t2_data", data_log[i], wrap_data[i]);
    end
    check("t2_last_at", last_at, 4);

    // Zero-length request
    clear_log();
    go(9'h055, 10'd0);
    check("t3_done", done_a, 1'b1);
    check("t3_busy", busy_a, 1'b1);
    check("t3_re", re_a, 1'b0);
    check("t3_valid", m_valid_a, 1'b0);
    tick();
    check("t3_done_off", done_a, 1'b0);
    check("t3_busy_off", busy_a, 1'b0);
    tick();
    check("t3_re_cnt", re_cnt, 0);
    check("t3_hs_cnt", hs_cnt, 0);

    // Backpressure: ready every third cycle
    clear_log();
    go(9'h040, 10'd16);
    k = 0;
    while (!done_a && k < 300) begin
      m_ready_a = (k % 3 == 0);
      tick();
      k++;
    end
    check("t4_done", done_a, 1'b1);
    m_ready_a = 1'b1;
    tick();
    check("t4_hs_cnt", hs_cnt, 16);
    check("t4_re_cnt", re_cnt, 16);
    for (int i = 0; i < 16; i++) begin
      if (i < data_log.size()) check("t4_data", data_log[i], 8'h40 + 8'(i));
    end
    check("t4_outstanding_le4", (max_out <= 4), 1'b1);
    check("t4_stall_stable", stall_err, 0);
    check("t4_last_cnt", last_cnt, 1);
    check("t4_last_at", last_at, 16);
    check("t4_done_cnt", done_cnt, 1);

    // Reset in the middle of a transfer, then a fresh short transfer
    clear_log();
    go(9'h030, 10'd20);
    k = 0;
    while (hs_cnt < 5 && k < 50) begin
      tick();
      k++;
    end
    check("t5_hs_before_rst", hs_cnt, 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_ctl", {busy_a, done_a, re_a, m_valid_a, m_last_a}, 5'b00000);
    check("t5_rst_raddr", raddr_a, 9'h000);
    check("t5_rst_data", m_data_a, 8'h00);
    @(posedge clk);
    #1;
    check("t5_rst_hold", {busy_a, re_a, m_valid_a}, 3'b000);
    rst_n = 1'b1;
    tick();
    clear_log();
    go(9'h020, 10'd2);
    run_until_done("t5_done", 40);
    tick();
    check("t5_hs_cnt", data_log.size(), 2);
    if (data_log.size() >= 2) begin
      check("t5_data0", data_log[0], 8'h20);
      check("t5_data1", data_log[1], 8'h21);
    end
    check("t5_last_at", last_at, 2);

    // Latency 1: full-RAM sweep at one word per clock
    sel = 1'b1;
    m_ready_b = 1'b1;
    clear_log();
    go(9'h000, 10'd512);
    check("t6_re_first", re_b, 1'b1);
    check("t6_valid_s1", m_valid_b, 1'b0);
    tick();
    check("t6_valid_s2", m_valid_b, 1'b0);
    tick();
    errs = 0;
    for (int i = 0; i < 512; i++) begin
      if (m_valid_b !== 1'b1 || m_data_b !== 8'(i) || m_last_b !== (i == 511)) errs++;
      tick();
    end
    check("t6_stream_errs", errs, 0);
    check("t6_done", done_b, 1'b1);
    tick();
    check("t6_hs_cnt", hs_cnt, 512);
    check("t6_re_cnt", re_cnt, 512);
    check("t6_last_cnt", last_cnt, 1);
    check("t6_done_cnt", done_cnt, 1);
    check("t6_busy_off", busy_b, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
